// File: rtl/uctl_ctrlahbtx_fill.sv
// uctl_ctrlahbtx_fill: splits a Tx DMA byte count into AHB read bursts, issuing each only when the Tx FIFO can take it whole.
module uctl_ctrlahbtx_fill #(
  parameter int CNTR_WD   = 20,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 uctl_sysClk,
  input  logic                 uctl_sysRst_n,
  input  logic [CNTR_WD-1:0]   dmaTx2ctrl_len,
  input  logic                 dmaTx2ctrl_sRdWr,
  input  logic                 dmaTx2ctrl_stransEn,
  input  logic [ADDR_SIZE-1:0] dmaTx2ctrl_sRdAddr,
  output logic                 ctrl2dmaTx_dn,
  input  logic [4:0]           space_inFifo,
  input  logic                 ahbc2ctrl_ack,
  input  logic                 ahbc2ctrl_addrDn,
  input  logic                 ahbc2ctrl_dataDn,
  input  logic [31:0]          ahbc2ctrl_sRdAddr,
  output logic                 ctrl2ahbc_trEn,
  output logic [4:0]           ctrl2ahbc_beats,
  output logic [2:0]           ctrl2ahbc_hSize,
  output logic [ADDR_SIZE-1:0] ctrl2ahbc_sRdAddr,
  output logic                 ctrl2ahbc_sRdWr
);
  typedef enum logic [2:0] {IDLE, SPACECHK, SUBTRREQ, SUBTRANS, WTDDN, DONE} state_t;
  localparam int MAX_BYTES = 16 * (DATA_SIZE / 8);
  state_t               state_q, state_d;
  logic [CNTR_WD-1:0]   nbytes_q, nbytes_d, delta;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 rdwr_q, rdwr_d, tren_q, tren_d, dn_q, dn_d, seen_q, seen_d;
  logic                 big, ge4, fits;
  logic [4:0]           need;
  // Full 16-beat bursts first, then one word burst for the remainder, then a byte burst for the tail.
  always_comb begin
    big   = |nbytes_q[CNTR_WD-1:6];
    ge4   = |nbytes_q[CNTR_WD-1:2];
    delta = big ? CNTR_WD'(MAX_BYTES) : ge4 ? CNTR_WD'({nbytes_q[6:2], 2'b00}) : nbytes_q;
    need  = big ? 5'd16 : ge4 ? nbytes_q[6:2] : 5'd1;
    fits  = space_inFifo >= need;
    ctrl2ahbc_beats = big ? 5'd16 : ge4 ? nbytes_q[6:2] : nbytes_q[4:0];
    ctrl2ahbc_hSize = ge4 ? 3'b010 : 3'b000;
  end
  always_comb begin
    state_d  = state_q;
    nbytes_d = nbytes_q;
    addr_d   = (ahbc2ctrl_addrDn && state_q != IDLE) ? ADDR_SIZE'(ahbc2ctrl_sRdAddr) : addr_q;
    rdwr_d   = rdwr_q;
    tren_d   = tren_q;
    seen_d   = seen_q;
    case (state_q)
      IDLE: if (dmaTx2ctrl_stransEn) begin
        nbytes_d = dmaTx2ctrl_len;
        addr_d   = dmaTx2ctrl_sRdAddr;
        rdwr_d   = dmaTx2ctrl_sRdWr;
        seen_d   = 1'b0;
        state_d  = SPACECHK;
      end
      // A job that issued bursts must wait for their data before reporting done.
      SPACECHK: if (nbytes_q == '0) state_d = (!seen_q || ahbc2ctrl_dataDn) ? DONE : WTDDN;
        else if (fits) begin
          tren_d  = 1'b1;
          state_d = SUBTRREQ;
        end
      SUBTRREQ: if (ahbc2ctrl_ack) begin
        nbytes_d = nbytes_q - delta;
        seen_d   = 1'b1;
        tren_d   = 1'b0;
        state_d  = ahbc2ctrl_addrDn ? SPACECHK : SUBTRANS;
      end
      SUBTRANS: state_d = ahbc2ctrl_addrDn ? SPACECHK : SUBTRANS;
      WTDDN:    state_d = ahbc2ctrl_dataDn ? DONE : WTDDN;
      default:  state_d = IDLE;
    endcase
    dn_d = state_d == DONE;
  end
  always_ff @(posedge uctl_sysClk or negedge uctl_sysRst_n)
    if (!uctl_sysRst_n) begin
      state_q  <= IDLE;
      nbytes_q <= '0;
      addr_q   <= '0;
      rdwr_q   <= 1'b0;
      tren_q   <= 1'b0;
      dn_q     <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nbytes_q <= nbytes_d;
      addr_q   <= addr_d;
      rdwr_q   <= rdwr_d;
      tren_q   <= tren_d;
      dn_q     <= dn_d;
      seen_q   <= seen_d;
    end
  assign ctrl2dmaTx_dn     = dn_q;
  assign ctrl2ahbc_trEn    = tren_q;
  assign ctrl2ahbc_sRdAddr = addr_q;
  assign ctrl2ahbc_sRdWr   = rdwr_q;
endmodule

// File: tb/tb_uctl_ctrlahbtx_fill.sv
// tb_uctl_ctrlahbtx_fill: directed scenario bench for the Tx fill controller.
module tb_uctl_ctrlahbtx_fill;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [19:0] len = '0;
  logic        rdwr = 1'b0, stran = 1'b0, ack = 1'b0, addr_dn = 1'b0, data_dn = 1'b0;
  logic [31:0] saddr = '0, ahb_addr = '0;
  logic [4:0]  space = 5'd16;
  logic        dn, tren, o_rdwr;
  logic [4:0]  beats;
  logic [2:0]  hsize;
  logic [31:0] o_addr;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  uctl_ctrlahbtx_fill dut (
    .uctl_sysClk(clk), .uctl_sysRst_n(rst_n),
    .dmaTx2ctrl_len(len), .dmaTx2ctrl_sRdWr(rdwr), .dmaTx2ctrl_stransEn(stran),
    .dmaTx2ctrl_sRdAddr(saddr), .ctrl2dmaTx_dn(dn), .space_inFifo(space),
    .ahbc2ctrl_ack(ack), .ahbc2ctrl_addrDn(addr_dn), .ahbc2ctrl_dataDn(data_dn),
    .ahbc2ctrl_sRdAddr(ahb_addr), .ctrl2ahbc_trEn(tren), .ctrl2ahbc_beats(beats),
    .ctrl2ahbc_hSize(hsize), .ctrl2ahbc_sRdAddr(o_addr), .ctrl2ahbc_sRdWr(o_rdwr)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [19:0] l, input logic [31:0] a, input logic w);
    len = l; saddr = a; rdwr = w; stran = 1'b1;
    tick();
    stran = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    tests++; if (tren !== 1'b0) begin fails++; $display("FAIL rst_tren got %0b want 0", tren); end
    tests++; if (dn !== 1'b0) begin fails++; $display("FAIL rst_dn got %0b want 0", dn); end
    tests++; if (o_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h want 0", o_addr); end
    tests++; if (o_rdwr !== 1'b0) begin fails++; $display("FAIL rst_rdwr got %0b want 0", o_rdwr); end
    tests++; if ({beats, hsize} !== 8'h00) begin fails++; $display("FAIL rst_beats_hsize got %0d/%b want 0/000", beats, hsize); end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_single_burst();
    start(20'd64, 32'h1000, 1'b0);
    tests++; if (tren !== 1'b0) begin fails++; $display("FAIL single_early_tren got %0b want 0", tren); end
    tick();
    tests++; if ({tren, beats, hsize} !== {1'b1, 5'd16, 3'b010}) begin fails++; $display("FAIL single_req got tren %0b beats %0d hsize %b want 1/16/010", tren, beats, hsize); end
    tests++; if (o_addr !== 32'h1000) begin fails++; $display("FAIL single_addr got %h want 1000", o_addr); end
    ack = 1'b1; addr_dn = 1'b1; ahb_addr = 32'h1040;
    tick();
    ack = 1'b0; addr_dn = 1'b0;
    tests++; if (tren !== 1'b0) begin fails++; $display("FAIL single_tren_drop got %0b want 0", tren); end
    tests++; if (o_addr !== 32'h1040) begin fails++; $display("FAIL single_next_addr got %h want 1040", o_addr); end
    tick();
    tests++; if ({tren, dn} !== 2'b00) begin fails++; $display("FAIL single_wtddn got tren/dn %b want 00", {tren, dn}); end
    data_dn = 1'b1;
    tick();
    data_dn = 1'b0;
    tests++; if (dn !== 1'b1) begin fails++; $display("FAIL single_dn got %0b want 1", dn); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({tren, dn} !== 2'b00) begin fails++; $display("FAIL single_after got tren/dn %b want 00", {tren, dn}); end
    end
  endtask
  task automatic test_multi_burst();
    start(20'd70, 32'h2000, 1'b0);
    tick();
    tests++; if ({tren, beats, hsize} !== {1'b1, 5'd16, 3'b010}) begin fails++; $display("FAIL multi_b1 got %0b/%0d/%b want 1/16/010", tren, beats, hsize); end
    ack = 1'b1; addr_dn = 1'b1; ahb_addr = 32'h2040;
    tick();
    ack = 1'b0; addr_dn = 1'b0;
    tests++; if (tren !== 1'b0) begin fails++; $display("FAIL multi_gap got %0b want 0", tren); end
    tick();
    tests++; if ({tren, beats, hsize} !== {1'b1, 5'd1, 3'b010}) begin fails++; $display("FAIL multi_b2 got %0b/%0d/%b want 1/1/010", tren, beats, hsize); end
    tests++; if (o_addr !== 32'h2040) begin fails++; $display("FAIL multi_b2_addr got %h want 2040", o_addr); end
    ack = 1'b1; addr_dn = 1'b1; ahb_addr = 32'h2044;
    tick();
    ack = 1'b0; addr_dn = 1'b0;
    tick();
    tests++; if ({tren, beats, hsize} !== {1'b1, 5'd2, 3'b000}) begin fails++; $display("FAIL multi_b3 got %0b/%0d/%b want 1/2/000", tren, beats, hsize); end
    tests++; if (o_addr !== 32'h2044) begin fails++; $display("FAIL multi_b3_addr got %h want 2044", o_addr); end
    ack = 1'b1; addr_dn = 1'b1; ahb_addr = 32'h2046;
    tick();
    ack = 1'b0; addr_dn = 1'b0;
    tick();
    tests++; if ({tren, dn} !== 2'b00) begin fails++; $display("FAIL multi_wait got tren/dn %b want 00", {tren, dn}); end
    data_dn = 1'b1;
    tick();
    data_dn = 1'b0;
    tests++; if (dn !== 1'b1) begin fails++; $display("FAIL multi_dn got %0b want 1", dn); end
    tick();
    tests++; if (dn !== 1'b0) begin fails++; $display("FAIL multi_dn_pulse got %0b want 0", dn); end
  endtask
  task automatic test_space_wait();
    int bad = 0;
    space = 5'd15;
    start(20'd64, 32'h3000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tren !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL space_hold got %0d cycles with trEn want 0", bad); end
    space = 5'd16;
    tick();
    tests++; if ({tren, beats} !== {1'b1, 5'd16}) begin fails++; $display("FAIL space_rise got %0b/%0d want 1/16", tren, beats); end
    ack = 1'b1; addr_dn = 1'b1; ahb_addr = 32'h3040;
    tick();
    ack = 1'b0; addr_dn = 1'b0; data_dn = 1'b1;
    tick();
    data_dn = 1'b0;
    tests++; if (dn !== 1'b1) begin fails++; $display("FAIL space_dn got %0b want 1", dn); end
    tick();
  endtask
  task automatic test_zero_len();
    start(20'd0, 32'h7000, 1'b0);
    tests++; if ({tren, dn} !== 2'b00) begin fails++; $display("FAIL zero_c1 got tren/dn %b want 00", {tren, dn}); end
    tick();
    tests++; if ({tren, dn} !== 2'b01) begin fails++; $display("FAIL zero_c2 got tren/dn %b want 01", {tren, dn}); end
    tick();
    tests++; if ({tren, dn} !== 2'b00) begin fails++; $display("FAIL zero_c3 got tren/dn %b want 00", {tren, dn}); end
  endtask
  task automatic test_busy_ignore();
    start(20'd128, 32'h4000, 1'b0);
    tick();
    len = 20'd0; saddr = 32'h9999; rdwr = 1'b1; stran = 1'b1;
    tick();
    stran = 1'b0;
    tests++; if ({tren, beats, o_rdwr} !== {1'b1, 5'd16, 1'b0} || o_addr !== 32'h4000) begin fails++; $display("FAIL busy_req got %0b/%0d/%0b/%h want 1/16/0/4000", tren, beats, o_rdwr, o_addr); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stran = (i == 1);
      tick();
      tests++; if ({tren, dn} !== 2'b00) begin fails++; $display("FAIL busy_subtrans got tren/dn %b want 00", {tren, dn}); end
    end
    stran = 1'b0; rdwr = 1'b0;
    addr_dn = 1'b1; ahb_addr = 32'h4040;
    tick();
    addr_dn = 1'b0;
    tests++; if (o_addr !== 32'h4040 || tren !== 1'b0) begin fails++; $display("FAIL busy_addrdn got %h/%0b want 4040/0", o_addr, tren); end
    tick();
    tests++; if ({tren, beats} !== {1'b1, 5'd16}) begin fails++; $display("FAIL busy_b2 got %0b/%0d want 1/16", tren, beats); end
    ack = 1'b1; addr_dn = 1'b1; ahb_addr = 32'h4080;
    tick();
    ack = 1'b0; addr_dn = 1'b0; data_dn = 1'b1;
    tick();
    data_dn = 1'b0;
    tests++; if (dn !== 1'b1) begin fails++; $display("FAIL busy_dn got %0b want 1", dn); end
    tick();
  endtask
  task automatic test_ack_split_reset();
    start(20'd100, 32'h5000, 1'b1);
    tick();
    tests++; if ({tren, beats, o_rdwr} !== {1'b1, 5'd16, 1'b1}) begin fails++; $display("FAIL split_b1 got %0b/%0d/%0b want 1/16/1", tren, beats, o_rdwr); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tests++; if ({tren, beats, hsize} !== {1'b0, 5'd9, 3'b010}) begin fails++; $display("FAIL split_ack got %0b/%0d/%b want 0/9/010", tren, beats, hsize); end
    repeat (2) tick();
    tests++; if (tren !== 1'b0) begin fails++; $display("FAIL split_hold got %0b want 0", tren); end
    addr_dn = 1'b1; ahb_addr = 32'h5040;
    tick();
    addr_dn = 1'b0;
    tick();
    tests++; if ({tren, beats} !== {1'b1, 5'd9} || o_addr !== 32'h5040) begin fails++; $display("FAIL split_b2 got %0b/%0d/%h want 1/9/5040", tren, beats, o_addr); end
    rst_n = 1'b0;
    #1;
    tests++; if ({tren, dn, o_rdwr} !== 3'b000 || o_addr !== 32'h0 || beats !== 5'd0) begin fails++; $display("FAIL midrst got %0b/%0b/%0b/%h/%0d want 0/0/0/0/0", tren, dn, o_rdwr, o_addr, beats); end
    tick();
    rst_n = 1'b1;
    tick();
    start(20'd8, 32'h6000, 1'b0);
    tick();
    tests++; if ({tren, beats, hsize} !== {1'b1, 5'd2, 3'b010} || o_addr !== 32'h6000) begin fails++; $display("FAIL postrst got %0b/%0d/%b/%h want 1/2/010/6000", tren, beats, hsize, o_addr); end
    ack = 1'b1; addr_dn = 1'b1; ahb_addr = 32'h6008;
    tick();
    ack = 1'b0; addr_dn = 1'b0; data_dn = 1'b1;
    tick();
    data_dn = 1'b0;
    tests++; if (dn !== 1'b1) begin fails++; $display("FAIL postrst_dn got %0b want 1", dn); end
    tick();
  endtask
  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_space_wait();
    test_zero_len();
    test_busy_ignore();
    test_ack_split_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uctl_ctrlahbtx_fill.md
# uctl_ctrlAhbTx_fill

Control logic for the transmit-side DMA path: fetches a DMA-requested byte count from system memory over the AHB master and fills the local transmit FIFO. It splits the request into AHB bursts sized by remaining length, and issues each burst only when the FIFO has room for the whole burst. It sits between the Tx DMA sequencer (request/done) and the AHB master controller (burst request/ack/done), and is the read-direction counterpart of the Rx drain controller.

## Interface
Parameters:
- CNTR_WD, 20, width of the byte-length counter
- ADDR_SIZE, 32, system address width
- DATA_SIZE, 32, AHB data width (word = 4 bytes); carried for consistency, no data passes through this block

Ports:
- uctl_sysClk  in  1  system clock; all logic on rising edge
- uctl_sysRst_n  in  1  asynchronous, active-low reset
- dmaTx2ctrl_len  in  CNTR_WD  bytes to fetch; sampled at start
- dmaTx2ctrl_sRdWr  in  1  AHB direction for this job (0 = read); sampled at start
- dmaTx2ctrl_stransEn  in  1  start pulse; honoured only in IDLE
- dmaTx2ctrl_sRdAddr  in  ADDR_SIZE  start system address; sampled at start
- ctrl2dmaTx_dn  out  1  registered one-cycle job-done pulse
- space_inFifo  in  5  free words in Tx FIFO (0..16)
- ahbc2ctrl_ack  in  1  AHB master accepted current burst request
- ahbc2ctrl_addrDn  in  1  address phase of current burst complete
- ahbc2ctrl_dataDn  in  1  all data of issued bursts complete
- ahbc2ctrl_sRdAddr  in  32  next address after completed address phase
- ctrl2ahbc_trEn  out  1  burst request, registered, held until ack
- ctrl2ahbc_beats  out  5  beats in burst
- ctrl2ahbc_hSize  out  3  HSIZE: 3'b010 word, 3'b000 byte
- ctrl2ahbc_sRdAddr  out  ADDR_SIZE  burst start address (registered)
- ctrl2ahbc_sRdWr  out  1  registered copy of dmaTx2ctrl_sRdWr

## Operation
- Registers: nBytes (CNTR_WD), addr (ADDR_SIZE), rdWr, trEn, dn, burstSeen flag, 3-bit state.
- Burst sizing (combinational from nBytes):
  - nBytes >= 64: hSize word, beats 16, delta 64 bytes, need 16 words.
  - 4 <= nBytes < 64: hSize word, beats = nBytes[6:2], delta = {nBytes[6:2],2'b00}, need = nBytes[6:2].
  - nBytes < 4: hSize byte, beats = nBytes[4:0], delta = nBytes, need 1 word.
- fits = (space_inFifo >= need).
- States:
  - IDLE: on stransEn load nBytes, addr, rdWr; clear burstSeen; -> SPACECHK.
  - SPACECHK: if nBytes == 0: if !burstSeen -> DONE; elif dataDn -> DONE; else -> WTDDN. Else if fits: trEn_nxt = 1, -> SUBTRREQ. Else stay.
  - SUBTRREQ: on ack: nBytes -= delta, burstSeen = 1, trEn_nxt = 0; addrDn same cycle -> SPACECHK, else -> SUBTRANS.
  - SUBTRANS: on addrDn -> SPACECHK.
  - WTDDN: on dataDn -> DONE.
  - DONE: dn high for this one cycle; -> IDLE.
- addr: loaded from dmaTx2ctrl_sRdAddr on start; otherwise updated from ahbc2ctrl_sRdAddr when addrDn and state != IDLE.
- nBytes subtraction never underflows (delta <= nBytes by construction).
- stransEn outside IDLE: ignored; no register changes.

## Timing
- Reset values: trEn 0, dn 0, sRdAddr 0, sRdWr 0, nBytes 0, state IDLE; beats/hSize follow nBytes = 0 (beats 0, hSize byte).
- Start at edge E (stransEn high in IDLE): state SPACECHK after E; earliest trEn high after E+1 (one cycle later).
- trEn stays high through SUBTRREQ until the cycle ack is sampled; low after that edge. beats/hSize/addr stable while trEn high (nBytes changes only on ack edge).
- Back-to-back bursts: ack+addrDn together -> SPACECHK next cycle -> next trEn one cycle after that (2-cycle gap minimum).
- Final completion: dataDn sampled in SPACECHK or WTDDN -> DONE next cycle -> dn high that cycle; IDLE the cycle after.
- Zero-length job: stransEn at E -> SPACECHK -> DONE; dn high 2 cycles after start, no trEn.
- Reset mid-operation: all registers return to reset values asynchronously; outstanding AHB burst is abandoned (AHB master reset by same signal).

## Test plan
- len 64, addr 0x1000, space 16: one request beats 16, hSize 010, addr 0x1000; after ack+addrDn and dataDn, dn pulses once; no second trEn.
- len 70, space 16: bursts (16 beats, word), (1 beat, word, addr from ahbc2ctrl_sRdAddr), (2 beats, byte); dn after final dataDn.
- len 64, space held at 15 for 20 cycles then 16: trEn stays 0 for those cycles, rises 1 cycle after space reaches 16.
- len 0: dn high exactly 2 cycles after stransEn; trEn never asserted; stransEn pulsed while busy on a 128-byte job ignored.
- ack without addrDn, addrDn 3 cycles later: state passes through SUBTRANS; next request not issued before addrDn; nBytes reduced by 64 at ack edge.
- Reset asserted while trEn high mid-job: trEn, dn, sRdAddr, sRdWr read 0 immediately; after release, fresh len 8 job issues beats 2 word.
